// File: rtl/friscv_cache_pkg.sv
// Shared types and constants for the data-cache write path.
package friscv_cache_pkg;

   localparam int WR_ADDR_W    = 32;
   localparam int WR_BLOCK_W   = 128;
   localparam int WR_STRB_W    = WR_BLOCK_W / 8;
   // Byte-offset bits inside one cache block; the bits above form the block index.
   localparam int BLK_OFFSET_W = $clog2(WR_STRB_W);

   typedef struct packed {
      logic [WR_ADDR_W-1:0]  addr;
      logic [WR_BLOCK_W-1:0] data;
      logic [WR_STRB_W-1:0]  strb;
   } wr_req_t;

   // Block index of a byte address.
   function automatic logic [WR_ADDR_W-BLK_OFFSET_W-1:0] blk_index(input logic [WR_ADDR_W-1:0] addr);
      return addr[WR_ADDR_W-1:BLK_OFFSET_W];
   endfunction

endpackage

// File: rtl/friscv_cache_wr_slot.sv
// One-entry request buffer: accepts when empty or when its content leaves this cycle.
module friscv_cache_wr_slot
   import friscv_cache_pkg::*;
(
   input  logic    aclk,
   input  logic    srst,
   input  logic    in_valid_i,
   output logic    in_ready_o,
   input  wr_req_t in_req_i,
   input  logic    grant_i,
   output logic    buf_valid_o,
   output wr_req_t buf_req_o
);

   logic    valid_q;
   wr_req_t req_q;

   assign in_ready_o  = !valid_q | grant_i;
   assign buf_valid_o = valid_q;
   assign buf_req_o   = req_q;

   // Capture on handshake; content is held until the arbiter grants it.
   always_ff @(posedge aclk) begin
      if (srst) begin
         valid_q <= 1'b0;
         req_q   <= '0;
      end else if (in_valid_i && in_ready_o) begin
         valid_q <= 1'b1;
         req_q   <= in_req_i;
      end else if (grant_i) begin
         valid_q <= 1'b0;
      end
   end

endmodule

// File: rtl/friscv_cache_wr_arbiter.sv
// Shares the cache block write port between the refill loader and the store pusher.
// Pusher wins by default; same-block conflicts and a starved loader go to the loader.
module friscv_cache_wr_arbiter
   import friscv_cache_pkg::*;
#(
   parameter int AXI_ADDR_W    = WR_ADDR_W,
   parameter int CACHE_BLOCK_W = WR_BLOCK_W,
   parameter int MAX_WAIT      = 4
)(
   input  logic                       aclk,
   input  logic                       srst,
   input  logic                       ld_wvalid,
   output logic                       ld_wready,
   input  logic [AXI_ADDR_W-1:0]      ld_waddr,
   input  logic [CACHE_BLOCK_W-1:0]   ld_wdata,
   input  logic [CACHE_BLOCK_W/8-1:0] ld_wstrb,
   input  logic                       pu_wvalid,
   output logic                       pu_wready,
   input  logic [AXI_ADDR_W-1:0]      pu_waddr,
   input  logic [CACHE_BLOCK_W-1:0]   pu_wdata,
   input  logic [CACHE_BLOCK_W/8-1:0] pu_wstrb,
   output logic                       cache_wen,
   output logic [AXI_ADDR_W-1:0]      cache_waddr,
   output logic [CACHE_BLOCK_W-1:0]   cache_wdata,
   output logic [CACHE_BLOCK_W/8-1:0] cache_wstrb,
   output logic                       busy
);

   localparam int AGE_W = $clog2(MAX_WAIT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

   wr_req_t ld_in, pu_in, ld_buf, pu_buf;
   logic    ld_v, pu_v;
   logic    grant_ld, grant_pu;
   logic    same_blk, starved;

   logic [AGE_W-1:0]           age_q;
   logic                       wen_q;
   logic [AXI_ADDR_W-1:0]      waddr_q;
   logic [CACHE_BLOCK_W-1:0]   wdata_q;
   logic [CACHE_BLOCK_W/8-1:0] wstrb_q;

   assign ld_in = '{addr: ld_waddr, data: ld_wdata, strb: ld_wstrb};
   assign pu_in = '{addr: pu_waddr, data: pu_wdata, strb: pu_wstrb};

   friscv_cache_wr_slot u_ld_slot (
      .aclk        (aclk),
      .srst        (srst),
      .in_valid_i  (ld_wvalid),
      .in_ready_o  (ld_wready),
      .in_req_i    (ld_in),
      .grant_i     (grant_ld),
      .buf_valid_o (ld_v),
      .buf_req_o   (ld_buf)
   );

   friscv_cache_wr_slot u_pu_slot (
      .aclk        (aclk),
      .srst        (srst),
      .in_valid_i  (pu_wvalid),
      .in_ready_o  (pu_wready),
      .in_req_i    (pu_in),
      .grant_i     (grant_pu),
      .buf_valid_o (pu_v),
      .buf_req_o   (pu_buf)
   );

   // Refill must land before a store into the same block so the store is not overwritten.
   always_comb begin
      same_blk = ld_v && pu_v && (blk_index(ld_buf.addr) == blk_index(pu_buf.addr));
      starved  = (age_q == AGE_MAX);
      grant_ld = ld_v && (!pu_v || same_blk || starved);
      grant_pu = pu_v && !grant_ld;
   end

   // Count consecutive losses of a waiting loader request, saturating at MAX_WAIT.
   always_ff @(posedge aclk) begin
      if (srst) begin
         age_q <= '0;
      end else if (!ld_v || grant_ld) begin
         age_q <= '0;
      end else if (grant_pu && !starved) begin
         age_q <= age_q + 1'b1;
      end
   end

   // Registered cache write port; address and data hold when idle.
   always_ff @(posedge aclk) begin
      if (srst) begin
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else if (grant_ld) begin
         wen_q   <= 1'b1;
         waddr_q <= ld_buf.addr;
         wdata_q <= ld_buf.data;
         wstrb_q <= ld_buf.strb;
      end else if (grant_pu) begin
         wen_q   <= 1'b1;
         waddr_q <= pu_buf.addr;
         wdata_q <= pu_buf.data;
         wstrb_q <= pu_buf.strb;
      end else begin
         wen_q   <= 1'b0;
         wstrb_q <= '0;
      end
   end

   assign cache_wen   = wen_q;
   assign cache_waddr = waddr_q;
   assign cache_wdata = wdata_q;
   assign cache_wstrb = wstrb_q;
   assign busy        = ld_v | pu_v | wen_q;

endmodule

// File: tb/tb_friscv_cache_wr_arbiter.sv
// Directed bench for the cache write arbiter.
module tb_friscv_cache_wr_arbiter;

   logic         aclk = 1'b0;
   logic         srst;
   logic         ld_wvalid, ld_wready;
   logic [31:0]  ld_waddr;
   logic [127:0] ld_wdata;
   logic [15:0]  ld_wstrb;
   logic         pu_wvalid, pu_wready;
   logic [31:0]  pu_waddr;
   logic [127:0] pu_wdata;
   logic [15:0]  pu_wstrb;
   logic         cache_wen;
   logic [31:0]  cache_waddr;
   logic [127:0] cache_wdata;
   logic [15:0]  cache_wstrb;
   logic         busy;

   int n_cmp  = 0;
   int n_fail = 0;
   logic [127:0] blk_mem;

   localparam logic [127:0] DATA_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
   localparam logic [127:0] DATA_B = {4{32'hDEADBEEF}};
   localparam logic [127:0] MERGED = 128'h00112233_44556677_DEADBEEF_CCDDEEFF;

   friscv_cache_wr_arbiter #(.AXI_ADDR_W(32), .CACHE_BLOCK_W(128), .MAX_WAIT(4)) dut (
      .aclk        (aclk),
      .srst        (srst),
      .ld_wvalid   (ld_wvalid),
      .ld_wready   (ld_wready),
      .ld_waddr    (ld_waddr),
      .ld_wdata    (ld_wdata),
      .ld_wstrb    (ld_wstrb),
      .pu_wvalid   (pu_wvalid),
      .pu_wready   (pu_wready),
      .pu_waddr    (pu_waddr),
      .pu_wdata    (pu_wdata),
      .pu_wstrb    (pu_wstrb),
      .cache_wen   (cache_wen),
      .cache_waddr (cache_waddr),
      .cache_wdata (cache_wdata),
      .cache_wstrb (cache_wstrb),
      .busy        (busy)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d,
                                          input logic [15:0] s);
      logic [127:0] r;
      r = old;
      for (int b = 0; b < 16; b++)
         if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   initial begin
      srst = 1'b1;
      ld_wvalid = 1'b0; ld_waddr = '0; ld_wdata = '0; ld_wstrb = '0;
      pu_wvalid = 1'b0; pu_waddr = '0; pu_wdata = '0; pu_wstrb = '0;
      blk_mem = '0;
      tick(); tick();
      srst = 1'b0;

      // Reset state
      check("rst_wen",   cache_wen,   0);
      check("rst_waddr", cache_waddr, 0);
      check("rst_wdata", cache_wdata, 0);
      check("rst_wstrb", cache_wstrb, 0);
      check("rst_busy",  busy,        0);
      check("rst_ldrdy", ld_wready,   1);
      check("rst_purdy", pu_wready,   1);

      // Loader alone
      ld_wvalid = 1'b1; ld_waddr = 32'h100; ld_wdata = DATA_A; ld_wstrb = 16'hFFFF;
      tick();
      check("ld_rdy_granted", ld_wready, 1);
      check("ld_wen_lat1",    cache_wen, 0);
      check("ld_busy",        busy,      1);
      ld_wvalid = 1'b0;
      tick();
      check("ld_wen",   cache_wen,   1);
      check("ld_waddr", cache_waddr, 32'h100);
      check("ld_wstrb", cache_wstrb, 16'hFFFF);
      check("ld_wdata", cache_wdata, DATA_A);
      check("ld_rdy",   ld_wready,   1);
      tick();
      check("ld_idle_wen",   cache_wen,   0);
      check("ld_idle_wstrb", cache_wstrb, 0);
      check("ld_hold_waddr", cache_waddr, 32'h100);
      check("ld_idle_busy",  busy,        0);

      // Pusher alone, back-to-back
      pu_wvalid = 1'b1; pu_waddr = 32'h204; pu_wdata = DATA_B; pu_wstrb = 16'h00F0;
      tick();
      check("pu_rdy_b2b", pu_wready, 1);
      pu_waddr = 32'h208; pu_wstrb = 16'h0F00;
      tick();
      pu_wvalid = 1'b0;
      check("pu1_wen",   cache_wen,   1);
      check("pu1_waddr", cache_waddr, 32'h204);
      check("pu1_wstrb", cache_wstrb, 16'h00F0);
      tick();
      check("pu2_wen",   cache_wen,   1);
      check("pu2_waddr", cache_waddr, 32'h208);
      check("pu2_wstrb", cache_wstrb, 16'h0F00);
      tick();
      check("pu_idle_wen", cache_wen, 0);

      // Simultaneous, different blocks: pusher first
      ld_wvalid = 1'b1; ld_waddr = 32'h300; ld_wstrb = 16'hFFFF; ld_wdata = DATA_A;
      pu_wvalid = 1'b1; pu_waddr = 32'h404; pu_wstrb = 16'h00F0; pu_wdata = DATA_B;
      tick();
      ld_wvalid = 1'b0; pu_wvalid = 1'b0;
      check("diff_ld_rdy", ld_wready, 0);
      check("diff_pu_rdy", pu_wready, 1);
      tick();
      check("diff_first_wen",   cache_wen,   1);
      check("diff_first_waddr", cache_waddr, 32'h404);
      tick();
      check("diff_second_wen",   cache_wen,   1);
      check("diff_second_waddr", cache_waddr, 32'h300);
      tick();
      check("diff_idle_wen", cache_wen, 0);

      // Same-block hazard: refill lands first, store merges on top
      blk_mem = '0;
      ld_wvalid = 1'b1; ld_waddr = 32'h500; ld_wstrb = 16'hFFFF; ld_wdata = DATA_A;
      pu_wvalid = 1'b1; pu_waddr = 32'h504; pu_wstrb = 16'h00F0; pu_wdata = DATA_B;
      tick();
      ld_wvalid = 1'b0; pu_wvalid = 1'b0;
      check("same_pu_rdy", pu_wready, 0);
      tick();
      check("same_first_waddr", cache_waddr, 32'h500);
      check("same_first_wstrb", cache_wstrb, 16'hFFFF);
      if (cache_wen) blk_mem = merge(blk_mem, cache_wdata, cache_wstrb);
      tick();
      check("same_second_waddr", cache_waddr, 32'h504);
      check("same_second_wstrb", cache_wstrb, 16'h00F0);
      if (cache_wen) blk_mem = merge(blk_mem, cache_wdata, cache_wstrb);
      check("same_final_block", blk_mem, MERGED);
      tick();

      // Starvation: loader forced after exactly MAX_WAIT pusher grants
      ld_wvalid = 1'b1; ld_waddr = 32'h600; ld_wstrb = 16'hFFFF;
      pu_wvalid = 1'b1; pu_waddr = 32'h704; pu_wstrb = 16'h000F;
      for (int i = 1; i <= 5; i++) begin
         tick();
         ld_wvalid = 1'b0;
         if (i >= 2) begin
            check("starve_pu_wen",   cache_wen,   1);
            check("starve_pu_waddr", cache_waddr, 32'h704 + 32'(4 * (i - 2)));
         end
         if (i < 5) pu_waddr = 32'h704 + 32'(4 * i);
      end
      check("starve_pu_blocked", pu_wready, 0);
      pu_wvalid = 1'b0;
      tick();
      check("starve_ld_wen",   cache_wen,   1);
      check("starve_ld_waddr", cache_waddr, 32'h600);
      tick();
      check("starve_tail_waddr", cache_waddr, 32'h714);
      tick();
      check("starve_idle_wen", cache_wen, 0);

      // Reset mid-operation, with a request presented during the reset cycle
      ld_wvalid = 1'b1; ld_waddr = 32'h800;
      pu_wvalid = 1'b1; pu_waddr = 32'h904;
      tick();
      pu_wvalid = 1'b0;
      ld_waddr = 32'hA00;
      srst = 1'b1;
      tick();
      srst = 1'b0;
      ld_wvalid = 1'b0;
      check("mrst_wen",   cache_wen,   0);
      check("mrst_waddr", cache_waddr, 0);
      check("mrst_busy",  busy,        0);
      check("mrst_ldrdy", ld_wready,   1);
      check("mrst_purdy", pu_wready,   1);
      tick();
      check("mrst_after_wen",  cache_wen, 0);
      check("mrst_after_busy", busy,      0);
      tick();
      check("mrst_after2_wen", cache_wen, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
